// File: rtl/hd44780_pkg.sv
// Shared HD44780 command bytes, ASCII constants and driver state types.
// HD44780_4BIT_EN selects the 4-bit function-set byte.
package hd44780_pkg;

    localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;
    localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DDRAM     = 8'h80;
    localparam logic [7:0] CMD_NOP       = 8'h00;

`ifdef HD44780_4BIT_EN
    localparam logic [7:0] CMD_FUNC_SET  = CMD_FUNC_4BIT;
`else
    localparam logic [7:0] CMD_FUNC_SET  = CMD_FUNC_8BIT;
`endif

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_QMARK   = 8'h3F;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_COLON   = 8'h3A;
    localparam logic [7:0] ASCII_M       = 8'h4D;
    localparam logic [7:0] ASCII_P       = 8'h50;
    localparam logic [7:0] ASCII_A       = 8'h41;

    localparam logic [3:0] NIB_INIT      = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_GAP
    } drv_state_t;

    typedef enum logic [1:0] {
        PH_INIT,
        PH_HI,
        PH_LO
    } nib_phase_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // A state lasting N cycles loads N-1; zero is stretched to one cycle.
    function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
        if (cyc <= 1) begin
            return '0;
        end
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/hd44780_char_encode.sv
// Combinational map from {data, sel, val} request codes to the HD44780 bus byte.
// HD44780_4BIT_EN changes the function-set command via the package.
module hd44780_char_encode
    import hd44780_pkg::*;
(
    input  logic       i_data,
    input  logic [2:0] i_sel,
    input  logic [3:0] i_val,
    output logic [7:0] o_byte
);

    logic [7:0] cmd_byte;
    logic [7:0] chr_byte;

    always_comb begin
        cmd_byte = CMD_NOP;
        unique case (i_sel)
            3'b100:  cmd_byte = CMD_FUNC_SET;
            3'b101:  cmd_byte = CMD_DISP_ON;
            3'b110:  cmd_byte = CMD_CLEAR;
            3'b111:  cmd_byte = CMD_ENTRY;
            3'b000:  cmd_byte = CMD_DDRAM | {4'b0, i_val};
            default: cmd_byte = CMD_NOP;
        endcase
    end

    always_comb begin
        chr_byte = ASCII_QMARK;
        unique case (i_sel[1:0])
            2'b00: chr_byte = (i_val <= 4'd9) ? ASCII_ZERO + {4'b0, i_val}
                                              : ASCII_QMARK;
            2'b01: chr_byte = i_val[0] ? ASCII_SPACE : ASCII_COLON;
            2'b10: chr_byte = ASCII_M;
            2'b11: chr_byte = i_val[0] ? ASCII_P : ASCII_A;
            default: chr_byte = ASCII_QMARK;
        endcase
    end

    assign o_byte = i_data ? chr_byte : cmd_byte;

endmodule

// File: rtl/hd44780_bus_driver.sv
// Write-only HD44780 bus driver: edge-triggered request, timed RS/DB/E strobe.
// Defining HD44780_4BIT_EN sends each byte as two nibble strobes on DB[7:4].
module hd44780_bus_driver
    import hd44780_pkg::*;
#(
    parameter int TSU_CYC  = 5,
    parameter int TPW_CYC  = 30,
    parameter int THD_CYC  = 5,
    parameter int TGAP_CYC = 100
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_data,
    input  logic       i_e_trigger,
    input  logic [2:0] i_sel,
    input  logic [3:0] i_val,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_db,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_drop
);

    localparam logic [CNT_W-1:0] LD_SU  = cyc_load(TSU_CYC);
    localparam logic [CNT_W-1:0] LD_PW  = cyc_load(TPW_CYC);
    localparam logic [CNT_W-1:0] LD_HD  = cyc_load(THD_CYC);
    localparam logic [CNT_W-1:0] LD_GAP = cyc_load(TGAP_CYC);

    drv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trig_q, trig_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    logic       rise;
    logic       idle;
    logic       start;
    logic       cnt_zero;
    logic       last_nib;
    logic [7:0] enc_byte;

    hd44780_char_encode u_encode (
        .i_data (i_data),
        .i_sel  (i_sel),
        .i_val  (i_val),
        .o_byte (enc_byte)
    );

    assign rise     = i_e_trigger & ~trig_q;
    assign idle     = (state_q == ST_IDLE);
    assign start    = rise & idle;
    assign cnt_zero = (cnt_q == '0);
    assign trig_d   = i_e_trigger;

`ifdef HD44780_4BIT_EN
    nib_phase_t phase_q, phase_d;
    logic [7:0] byte_q, byte_d;
    logic       init_q, init_d;

    assign last_nib = (phase_q == PH_LO);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q <= PH_INIT;
            byte_q  <= 8'h00;
            init_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            byte_q  <= byte_d;
            init_q  <= init_d;
        end
    end
`else
    assign last_nib = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b1;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    cnt_d   = LD_SU;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_EHIGH;
                    cnt_d   = LD_PW;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_EHIGH: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = last_nib ? ST_IDLE : ST_GAP;
                    cnt_d   = last_nib ? '0 : LD_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef HD44780_4BIT_EN
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_SETUP;
                    cnt_d   = LD_SU;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so E never glitches.
    always_comb begin
        rs_d   = rs_q;
        db_d   = db_q;
        e_d    = (state_d == ST_EHIGH);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_HOLD) && (cnt_d == '0) && last_nib;
        drop_d = rise & ~idle;
`ifdef HD44780_4BIT_EN
        phase_d = phase_q;
        byte_d  = byte_q;
        init_d  = init_q;
        if (start) begin
            rs_d    = i_data;
            byte_d  = enc_byte;
            init_d  = 1'b1;
            phase_d = init_q ? PH_HI : PH_INIT;
            db_d    = init_q ? {enc_byte[7:4], 4'h0} : {NIB_INIT, 4'h0};
        end else if (state_q == ST_GAP && state_d == ST_SETUP) begin
            phase_d = (phase_q == PH_INIT) ? PH_HI : PH_LO;
            db_d    = (phase_q == PH_INIT) ? {byte_q[7:4], 4'h0}
                                           : {byte_q[3:0], 4'h0};
        end
`else
        if (start) begin
            rs_d = i_data;
            db_d = enc_byte;
        end
`endif
    end

    assign o_lcd_rs = rs_q;
    assign o_lcd_rw = 1'b0;
    assign o_lcd_e  = e_q;
    assign o_lcd_db = db_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_drop   = drop_q;

endmodule
